// File: rtl/alu_exec_if.sv
// Handshake/operand bundle between the register-read stage and the ALU execute unit.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_sel;
    logic             alu_src;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             illegal;

    modport master (
        output start, alu_sel, alu_src, rs_val, rt_val, imm,
        input  busy, done, result, carry, zero, sign, illegal
    );

    modport slave (
        input  start, alu_sel, alu_src, rs_val, rt_val, imm,
        output busy, done, result, carry, zero, sign, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic, iterative shifts and DIFF scan.
// Optional macro BARREL_SHIFT_EN makes all shifts complete in one cycle.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SCAN, S_DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b1000;
    localparam logic [3:0] OP_DIFF = 4'b1001;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [3:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 sc_q, sc_d;
    logic [WIDTH-1:0]     result_q;
    logic                 carry_q, zero_q, sign_q, illegal_q, done_q, busy_q;

    logic [WIDTH-1:0]     b_s, diff_s, fin_res_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 fin_s, fin_c_s, fin_ill_s;

`ifdef BARREL_SHIFT_EN
    // Returns {carry, result}; the extra bit catches the last bit shifted out.
    function automatic logic [WIDTH:0] barrel(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                              input logic [SHAMT_W-1:0] s);
        logic [WIDTH:0] t;
        case (op)
            OP_SLL:  begin t = {1'b0, a} << s;                       barrel = t; end
            OP_SRL:  begin t = {a, 1'b0} >> s;                       barrel = {t[0], t[WIDTH:1]}; end
            OP_SRA:  begin t = (WIDTH+1)'($signed({a, 1'b0}) >>> s); barrel = {t[0], t[WIDTH:1]}; end
            default: begin t = '0;                                   barrel = t; end
        endcase
    endfunction
`endif

    // Next-state, working-register and completion-value logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        x_d       = x_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        sc_d      = sc_q;
        fin_s     = 1'b0;
        fin_res_s = '0;
        fin_c_s   = 1'b0;
        fin_ill_s = 1'b0;
        b_s       = bus.alu_src ? bus.imm : bus.rt_val;
        shamt_s   = b_s[SHAMT_W-1:0];
        diff_s    = bus.rs_val ^ b_s;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d = bus.alu_sel;
                    case (bus.alu_sel)
                        OP_ADD:  begin {fin_c_s, fin_res_s} = {1'b0, bus.rs_val} + {1'b0, b_s}; fin_s = 1'b1; end
                        OP_COMP: begin fin_res_s = (~b_s) + {{(WIDTH-1){1'b0}}, 1'b1}; fin_s = 1'b1; end
                        OP_AND:  begin fin_res_s = bus.rs_val & b_s; fin_s = 1'b1; end
                        OP_XOR:  begin fin_res_s = bus.rs_val ^ b_s; fin_s = 1'b1; end
                        OP_PASS: begin fin_res_s = bus.rs_val; fin_s = 1'b1; end
                        OP_SLL, OP_SRL, OP_SRA: begin
`ifdef BARREL_SHIFT_EN
                            {fin_c_s, fin_res_s} = barrel(bus.alu_sel, bus.rs_val, shamt_s);
                            fin_s = 1'b1;
`else
                            if (shamt_s == {SHAMT_W{1'b0}}) begin
                                fin_res_s = bus.rs_val;
                                fin_s     = 1'b1;
                            end else begin
                                acc_d   = bus.rs_val;
                                cnt_d   = shamt_s;
                                sc_d    = 1'b0;
                                state_d = S_SHIFT;
                            end
`endif
                        end
                        OP_DIFF: begin
                            // Bit 0 is tested on the accept edge so latency is index+1.
                            if (diff_s[0]) begin
                                fin_res_s = '0;
                                fin_s     = 1'b1;
                            end else begin
                                x_d     = diff_s;
                                cnt_d   = SHAMT_W'(1);
                                state_d = S_SCAN;
                            end
                        end
                        default: begin fin_ill_s = 1'b1; fin_s = 1'b1; end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  begin sc_d = acc_q[WIDTH-1]; acc_d = {acc_q[WIDTH-2:0], 1'b0}; end
                    OP_SRL:  begin sc_d = acc_q[0];       acc_d = {1'b0, acc_q[WIDTH-1:1]}; end
                    OP_SRA:  begin sc_d = acc_q[0];       acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; end
                    default: begin sc_d = 1'b0;           acc_d = acc_q; end
                endcase
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    fin_res_s = acc_d;
                    fin_c_s   = sc_d;
                    fin_s     = 1'b1;
                end else begin
                    fin_s     = 1'b0;
                end
            end
            S_SCAN: begin
                if (x_q[cnt_q]) begin
                    fin_res_s = WIDTH'(cnt_q);
                    fin_s     = 1'b1;
                end else if (cnt_q == SHAMT_W'(WIDTH-1)) begin
                    fin_res_s = WIDTH'(WIDTH);
                    fin_s     = 1'b1;
                end else begin
                    cnt_d = cnt_q + SHAMT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fin_s) begin
            state_d = S_DONE;
        end else begin
            state_d = state_d;
        end
    end

    // State, working registers and registered outputs; result/flags only change on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            x_q       <= '0;
            op_q      <= 4'b0000;
            cnt_q     <= '0;
            sc_q      <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            sign_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            sc_q      <= sc_d;
            done_q    <= fin_s;
            illegal_q <= fin_s & fin_ill_s;
            busy_q    <= (state_d == S_SHIFT) || (state_d == S_SCAN);
            if (fin_s) begin
                result_q <= fin_res_s;
                carry_q  <= fin_c_s;
                zero_q   <= (fin_res_s == '0);
                sign_q   <= fin_res_s[WIDTH-1];
            end else begin
                result_q <= result_q;
                carry_q  <= carry_q;
                zero_q   <= zero_q;
                sign_q   <= sign_q;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign bus.sign    = sign_q;
    assign bus.illegal = illegal_q;
endmodule
